// File: rtl/boot_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM encoding,
// default memory geometry and the stream header width.
package boot_pkg;

   localparam int DEPTH_DEF  = 256;
   localparam int ADDR_W_DEF = 8;
   localparam int HDR_W      = 16;

   typedef enum logic [2:0] {
      LEN_HI = 3'd0,
      LEN_LO = 3'd1,
      DATA   = 3'd2,
      CSUM   = 3'd3,
      DONE   = 3'd4,
      ERROR  = 3'd5
   } state_t;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Packs four stream bytes, MSB first, into a 32-bit word and pulses
// word_valid for one cycle after the fourth byte is taken.
module word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_valid,
   output logic        last_byte
);

   logic [1:0]  idx;
   logic [23:0] shreg;

   // Lets the FSM act on the word-closing byte in the same cycle it is accepted.
   assign last_byte = (idx == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= '0;
         shreg      <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (byte_en) begin
            idx   <= idx + 2'd1;
            shreg <= {shreg[15:0], byte_data};
            if (last_byte) begin
               word       <= {shreg, byte_data};
               word_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction
// memory and holds the core in reset until the image is verified.
module boot_loader
   import boot_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   localparam logic [HDR_W-1:0] DEPTH_N = HDR_W'(DEPTH);

   state_t             state;
   logic [HDR_W-1:0]   len;
   logic [ADDR_W:0]    word_cnt;
   logic [ADDR_W:0]    cnt_nxt;
   logic [7:0]         csum;
   logic [HDR_W-1:0]   len_full;
   logic               accept;
   logic               byte_en;
   logic               last_byte;

   assign in_ready = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == DATA)   || (state == CSUM);
   assign accept   = in_valid && in_ready;
   assign byte_en  = accept && (state == DATA);
   assign len_full = {len[HDR_W-1:8], in_data};
   assign cnt_nxt  = word_cnt + 1'b1;

   word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .byte_en    (byte_en),
      .byte_data  (in_data),
      .word       (imem_wdata),
      .word_valid (imem_we),
      .last_byte  (last_byte)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LEN_HI;
         len       <= '0;
         word_cnt  <= '0;
         csum      <= '0;
         imem_addr <= '0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else if (accept) begin
         case (state)
            LEN_HI: begin
               len[HDR_W-1:8] <= in_data;
               state          <= LEN_LO;
            end
            LEN_LO: begin
               len <= len_full;
               if (len_full > DEPTH_N) begin
                  state <= ERROR;
                  error <= 1'b1;
               end else if (len_full == '0) begin
                  state <= CSUM;
               end else begin
                  state <= DATA;
               end
            end
            DATA: begin
               csum <= csum ^ in_data;
               // Address is latched alongside the assembler's word register so both land together.
               if (last_byte) begin
                  imem_addr <= word_cnt[ADDR_W-1:0];
                  word_cnt  <= cnt_nxt;
                  if (HDR_W'(cnt_nxt) == len) state <= CSUM;
               end
            end
            CSUM: begin
               if (in_data == csum) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
               end else begin
                  state <= ERROR;
                  error <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: cycle-accurate vector tables for the basic
// good/bad image, plus hand sequences for oversize, empty, mid-load reset and full-size loads.
module tb_boot_loader;

   logic        clk = 1'b0;
   logic        reset, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, imem_we, cpu_reset, done, error;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;

   always #5 clk = ~clk;

   boot_loader #(.DEPTH(256), .ADDR_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .error      (error)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int drops = 0;

   logic [7:0]  wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
         wr_cyc.push_back(cyc);
      end
   end

   typedef struct {
      logic        rst;
      logic        vld;
      logic [7:0]  d;
      logic        rdy;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wd;
      logic        dn;
      logic        er;
      logic        cr;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic vld, input logic [7:0] d,
                      input logic rdy, input logic we, input logic [7:0] a,
                      input logic [31:0] wd, input logic dn, input logic er, input logic cr);
      vec_t v;
      v.rst = rst; v.vld = vld; v.d = d; v.rdy = rdy; v.we = we;
      v.addr = a; v.wd = wd; v.dn = dn; v.er = er; v.cr = cr;
      tbl.push_back(v);
   endtask

   // N=2 image 0x8C010004, 0x00221820; good checksum is 0x93.
   task automatic build(input logic [7:0] cs, input logic good);
      logic [7:0]  b[8];
      logic [31:0] w0, w1, wd;
      w0 = 32'h8C010004;
      w1 = 32'h00221820;
      b[0] = 8'h8C; b[1] = 8'h01; b[2] = 8'h00; b[3] = 8'h04;
      b[4] = 8'h00; b[5] = 8'h22; b[6] = 8'h18; b[7] = 8'h20;
      tbl.delete();
      add(1, 0, 8'h00, 1, 0, 8'd0, 32'h0, 0, 0, 1);
      add(0, 1, 8'h00, 1, 0, 8'd0, 32'h0, 0, 0, 1);
      add(0, 1, 8'h02, 1, 0, 8'd0, 32'h0, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         wd = (i < 3) ? 32'h0 : (i < 7) ? w0 : w1;
         add(0, 1, b[i], 1, (i == 3 || i == 7), (i >= 7) ? 8'd1 : 8'd0, wd, 0, 0, 1);
      end
      add(0, 1, cs,    0, 0, 8'd1, w1, good, !good, !good);
      add(0, 1, 8'h55, 0, 0, 8'd1, w1, good, !good, !good);
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         reset    = tbl[i].rst;
         in_valid = tbl[i].vld;
         in_data  = tbl[i].d;
         @(posedge clk); #1;
         chk($sformatf("%s[%0d].rdy",  tag, i), 32'(in_ready),  32'(tbl[i].rdy));
         chk($sformatf("%s[%0d].we",   tag, i), 32'(imem_we),   32'(tbl[i].we));
         chk($sformatf("%s[%0d].addr", tag, i), 32'(imem_addr), 32'(tbl[i].addr));
         chk($sformatf("%s[%0d].wd",   tag, i), imem_wdata,     tbl[i].wd);
         chk($sformatf("%s[%0d].done", tag, i), 32'(done),      32'(tbl[i].dn));
         chk($sformatf("%s[%0d].err",  tag, i), 32'(error),     32'(tbl[i].er));
         chk($sformatf("%s[%0d].cpur", tag, i), 32'(cpu_reset), 32'(tbl[i].cr));
      end
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready !== 1'b1) drops++;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_gap(input logic [7:0] b);
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk); #1;
      end
      send(b);
   endtask

   initial begin
      int n0, bad_addr, bad_data, bad_gap;
      logic [7:0]  x;
      logic [31:0] w;
      logic [7:0]  ib;
      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;

      build(8'h93, 1'b1);
      run_table("good");
      build(8'h93 ^ 8'hFF, 1'b0);
      run_table("badcs");

      // Oversize header: 257 words
      do_reset();
      n0 = wr_addr.size();
      send(8'h01); send(8'h01);
      chk("big.err",  32'(error),    32'd1);
      chk("big.done", 32'(done),     32'd0);
      chk("big.rdy",  32'(in_ready), 32'd0);
      chk("big.cpur", 32'(cpu_reset), 32'd1);
      repeat (2) @(posedge clk); #1;
      chk("big.writes", 32'(wr_addr.size() - n0), 32'd0);

      // Empty image
      do_reset();
      n0 = wr_addr.size();
      send(8'h00); send(8'h00); send(8'h00);
      chk("empty.done", 32'(done),      32'd1);
      chk("empty.cpur", 32'(cpu_reset), 32'd0);
      chk("empty.err",  32'(error),     32'd0);
      repeat (2) @(posedge clk); #1;
      chk("empty.writes", 32'(wr_addr.size() - n0), 32'd0);

      // N=3 with gaps, reset after the 6th data byte, then a fresh N=1 image
      do_reset();
      n0 = wr_addr.size();
      send_gap(8'h00); send_gap(8'h03);
      send_gap(8'h11); send_gap(8'h22); send_gap(8'h33); send_gap(8'h44);
      send_gap(8'h55); send_gap(8'h66);
      repeat (2) @(posedge clk); #1;
      do_reset();
      chk("mid.cpur", 32'(cpu_reset), 32'd1);
      chk("mid.rdy",  32'(in_ready),  32'd1);
      repeat (3) @(posedge clk); #1;
      chk("mid.writes", 32'(wr_addr.size() - n0), 32'd1);
      if (wr_addr.size() > n0) begin
         chk("mid.addr0", 32'(wr_addr[n0]), 32'd0);
         chk("mid.data0", wr_data[n0], 32'h11223344);
      end
      send(8'h00); send(8'h01);
      send(8'h20); send(8'h02); send(8'h00); send(8'h05);
      send(8'h27);
      repeat (2) @(posedge clk); #1;
      chk("fresh.writes", 32'(wr_addr.size() - n0), 32'd2);
      chk("fresh.addr", 32'(wr_addr[wr_addr.size()-1]), 32'd0);
      chk("fresh.data", wr_data[wr_data.size()-1], 32'h20020005);
      chk("fresh.done", 32'(done), 32'd1);

      // Full 256-word image at full rate
      do_reset();
      n0 = wr_addr.size();
      drops = 0;
      x = 8'h00;
      send(8'h01); send(8'h00);
      for (int i = 0; i < 256; i++) begin
         ib = 8'(i);
         w  = {ib, ib ^ 8'hA5, ~ib, 8'h3C};
         for (int k = 3; k >= 0; k--) begin
            send(w[k*8 +: 8]);
            x = x ^ w[k*8 +: 8];
         end
      end
      send(x);
      repeat (2) @(posedge clk); #1;
      chk("full.writes", 32'(wr_addr.size() - n0), 32'd256);
      bad_addr = 0; bad_data = 0; bad_gap = 0;
      for (int i = 0; i < 256 && (n0 + i) < wr_addr.size(); i++) begin
         ib = 8'(i);
         w  = {ib, ib ^ 8'hA5, ~ib, 8'h3C};
         if (wr_addr[n0+i] !== ib) bad_addr++;
         if (wr_data[n0+i] !== w) bad_data++;
         if (i > 0 && (wr_cyc[n0+i] - wr_cyc[n0+i-1]) != 4) bad_gap++;
      end
      chk("full.bad_addr", 32'(bad_addr), 32'd0);
      chk("full.bad_data", 32'(bad_data), 32'd0);
      chk("full.bad_gap",  32'(bad_gap),  32'd0);
      chk("full.rdy_drops", 32'(drops),   32'd0);
      chk("full.done", 32'(done),      32'd1);
      chk("full.cpur", 32'(cpu_reset), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
